// File: rtl/vga_sync_param.sv
// Parametrised VGA timing generator: pixel-tick divider, x/y counters, registered sync/video decode.
// Defining VGA_FRAME_CNT_EN adds an 8-bit frame counter output (frame_cnt).
module vga_sync_param #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int CLK_DIV  = 4,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int XW       = 10,
  parameter int YW       = 10
) (
  input  logic          reloj_nexys,
  input  logic          reset_total,
  input  logic          enable,
  output logic          pix_tick,
  output logic [XW-1:0] x_p,
  output logic [YW-1:0] y_p,
  output logic          hsync,
  output logic          vsync,
  output logic          ON_VID,
  output logic          line_start,
`ifdef VGA_FRAME_CNT_EN
  output logic          frame_start,
  output logic [7:0]    frame_cnt
`else
  output logic          frame_start
`endif
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [XW-1:0] H_LAST   = XW'(H_TOTAL - 1);
  localparam logic [YW-1:0] V_LAST   = YW'(V_TOTAL - 1);
  localparam logic [3:0]    DIV_LAST = 4'(CLK_DIV - 1);

  localparam logic [31:0] H_ACT_END = 32'(H_ACTIVE);
  localparam logic [31:0] HS_START  = 32'(H_ACTIVE + H_FP);
  localparam logic [31:0] HS_END    = 32'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [31:0] V_ACT_END = 32'(V_ACTIVE);
  localparam logic [31:0] VS_START  = 32'(V_ACTIVE + V_FP);
  localparam logic [31:0] VS_END    = 32'(V_ACTIVE + V_FP + V_SYNC);

  if (CLK_DIV < 2 || CLK_DIV > 16) begin : g_bad_div
    $error("vga_sync_param: CLK_DIV must be in 2..16");
  end
  if (H_TOTAL > (1 << XW) || V_TOTAL > (1 << YW)) begin : g_bad_width
    $error("vga_sync_param: H_TOTAL/V_TOTAL do not fit XW/YW");
  end

  logic [3:0]    r_div_cnt;
  logic          r_pix_tick;
  logic [XW-1:0] r_x;
  logic [YW-1:0] r_y;
  logic          r_hsync;
  logic          r_vsync;
  logic          r_on_vid;
  logic          r_line_start;
  logic          r_frame_start;
`ifdef VGA_FRAME_CNT_EN
  logic [7:0]    r_frame_cnt;
`endif

  logic [31:0] w_x32;
  logic [31:0] w_y32;
  logic        w_on_vid;
  logic        w_hs_act;
  logic        w_vs_act;

  // Decode looks at the counters as they stand now, so outputs trail x_p/y_p by one clock.
  assign w_x32    = 32'(r_x);
  assign w_y32    = 32'(r_y);
  assign w_on_vid = (w_x32 < H_ACT_END) && (w_y32 < V_ACT_END);
  assign w_hs_act = (w_x32 >= HS_START) && (w_x32 < HS_END);
  assign w_vs_act = (w_y32 >= VS_START) && (w_y32 < VS_END);

  always_ff @(posedge reloj_nexys) begin
    if (reset_total) begin
      r_div_cnt     <= '0;
      r_pix_tick    <= 1'b0;
      r_x           <= '0;
      r_y           <= '0;
      r_hsync       <= ~HS_POL;
      r_vsync       <= ~VS_POL;
      r_on_vid      <= 1'b0;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
`ifdef VGA_FRAME_CNT_EN
      r_frame_cnt   <= '0;
`endif
    end else begin
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
      if (enable) begin
        if (r_div_cnt == DIV_LAST) begin
          r_div_cnt  <= '0;
          r_pix_tick <= 1'b1;
        end else begin
          r_div_cnt  <= r_div_cnt + 4'd1;
          r_pix_tick <= 1'b0;
        end
        // A tick is only consumed while enabled so the counters freeze completely.
        if (r_pix_tick) begin
          if (r_x == H_LAST) begin
            r_x          <= '0;
            r_line_start <= 1'b1;
            if (r_y == V_LAST) begin
              r_y           <= '0;
              r_frame_start <= 1'b1;
`ifdef VGA_FRAME_CNT_EN
              r_frame_cnt   <= r_frame_cnt + 8'd1;
`endif
            end else begin
              r_y <= r_y + 1'b1;
            end
          end else begin
            r_x <= r_x + 1'b1;
          end
        end
      end else begin
        r_pix_tick <= 1'b0;
      end
      r_on_vid <= w_on_vid;
      r_hsync  <= w_hs_act ? HS_POL : ~HS_POL;
      r_vsync  <= w_vs_act ? VS_POL : ~VS_POL;
    end
  end

  assign pix_tick    = r_pix_tick;
  assign x_p         = r_x;
  assign y_p         = r_y;
  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign ON_VID      = r_on_vid;
  assign line_start  = r_line_start;
  assign frame_start = r_frame_start;
`ifdef VGA_FRAME_CNT_EN
  assign frame_cnt   = r_frame_cnt;
`endif

endmodule

// File: tb/tb_vga_sync_param.sv
// Bench for vga_sync_param: default-timing and small-timing instances checked against
// a pixel-count reference model; frame_cnt checks are included when VGA_FRAME_CNT_EN is defined.
module tb_vga_sync_param;

  typedef struct {
    int ha, hfp, hsw, hbp, va, vfp, vsw, vbp, cd;
    bit hp, vp;
  } cfg_t;

  // Model state is a count of enabled clocks and of consumed pixels; positions follow by division.
  typedef struct {
    int en_clks;
    bit tick;
    int pix;
    bit ls, fs;
    bit dec_valid;
    int dec_pix;
    int x, y, fc;
    bit on, hs, vs;
  } m_t;

  cfg_t cfg_d = '{640, 16, 96, 48, 480, 10, 2, 33, 4, 1'b0, 1'b0};
  cfg_t cfg_s = '{4, 1, 2, 1, 3, 1, 1, 1, 2, 1'b1, 1'b0};
  m_t   md;
  m_t   ms;

  logic clk, rst, en;
  logic       d_tick, d_hs, d_vs, d_on, d_ls, d_fs;
  logic [9:0] d_x, d_y;
  logic       s_tick, s_hs, s_vs, s_on, s_ls, s_fs;
  logic [3:0] s_x, s_y;
`ifdef VGA_FRAME_CNT_EN
  logic [7:0] d_fc, s_fc;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  vga_sync_param dut_d (
    .reloj_nexys(clk), .reset_total(rst), .enable(en), .pix_tick(d_tick),
    .x_p(d_x), .y_p(d_y), .hsync(d_hs), .vsync(d_vs), .ON_VID(d_on),
    .line_start(d_ls),
`ifdef VGA_FRAME_CNT_EN
    .frame_start(d_fs), .frame_cnt(d_fc)
`else
    .frame_start(d_fs)
`endif
  );

  vga_sync_param #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1), .V_ACTIVE(3), .V_FP(1), .V_SYNC(1),
    .V_BP(1), .CLK_DIV(2), .HS_POL(1'b1), .VS_POL(1'b0), .XW(4), .YW(4)
  ) dut_s (
    .reloj_nexys(clk), .reset_total(rst), .enable(en), .pix_tick(s_tick),
    .x_p(s_x), .y_p(s_y), .hsync(s_hs), .vsync(s_vs), .ON_VID(s_on),
    .line_start(s_ls),
`ifdef VGA_FRAME_CNT_EN
    .frame_start(s_fs), .frame_cnt(s_fc)
`else
    .frame_start(s_fs)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic m_t step(m_t m_in, cfg_t c, bit r, bit e);
    m_t m;
    int ht, vt, dx, dy;
    m  = m_in;
    ht = c.ha + c.hfp + c.hsw + c.hbp;
    vt = c.va + c.vfp + c.vsw + c.vbp;
    if (r) begin
      m.en_clks = 0; m.tick = 1'b0; m.pix = 0; m.ls = 1'b0; m.fs = 1'b0;
      m.dec_valid = 1'b0; m.dec_pix = 0;
    end else begin
      m.dec_valid = 1'b1;
      m.dec_pix   = m.pix;
      m.ls = 1'b0; m.fs = 1'b0;
      if (e) begin
        if (m.tick) begin
          m.pix++;
          m.ls = (m.pix % ht == 0);
          m.fs = (m.pix % (ht * vt) == 0);
        end
        m.en_clks++;
        m.tick = (m.en_clks % c.cd == 0);
      end else begin
        m.tick = 1'b0;
      end
    end
    m.x  = m.pix % ht;
    m.y  = (m.pix / ht) % vt;
    m.fc = (m.pix / (ht * vt)) % 256;
    dx   = m.dec_pix % ht;
    dy   = (m.dec_pix / ht) % vt;
    if (!m.dec_valid) begin
      m.on = 1'b0; m.hs = ~c.hp; m.vs = ~c.vp;
    end else begin
      m.on = (dx < c.ha) && (dy < c.va);
      m.hs = (dx >= c.ha + c.hfp && dx < c.ha + c.hfp + c.hsw) ? c.hp : ~c.hp;
      m.vs = (dy >= c.va + c.vfp && dy < c.va + c.vfp + c.vsw) ? c.vp : ~c.vp;
    end
    return m;
  endfunction

  always @(posedge clk) begin
    md = step(md, cfg_d, rst, en);
    ms = step(ms, cfg_s, rst, en);
  end

  logic [25:0] d_obs, d_exp;
  logic [13:0] s_obs, s_exp;
  assign d_obs = {d_x, d_y, d_tick, d_on, d_hs, d_vs, d_ls, d_fs};
  assign d_exp = {10'(md.x), 10'(md.y), md.tick, md.on, md.hs, md.vs, md.ls, md.fs};
  assign s_obs = {s_x, s_y, s_tick, s_on, s_hs, s_vs, s_ls, s_fs};
  assign s_exp = {4'(ms.x), 4'(ms.y), ms.tick, ms.on, ms.hs, ms.vs, ms.ls, ms.fs};

  task automatic test_reset();
    rst = 1'b1; en = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (d_obs !== {20'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL reset_default got=%h exp=%h", d_obs, {20'd0, 6'b001100});
    end
    n_checks++;
    if (s_obs !== {8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL reset_small got=%h exp=%h", s_obs, {8'd0, 6'b000100});
    end
`ifdef VGA_FRAME_CNT_EN
    n_checks++;
    if (d_fc !== 8'd0 || s_fc !== 8'd0) begin
      n_fail++; $display("FAIL reset_frame_cnt got=%0d/%0d exp=0", d_fc, s_fc);
    end
`endif
  endtask

  task automatic test_first_tick();
    int first_d, first_s, nd, ns, nstrobe;
    first_d = 0; first_s = 0; nd = 0; ns = 0; nstrobe = 0;
    rst = 1'b0; en = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (d_tick) begin nd++; if (first_d == 0) first_d = k; end
      if (s_tick) begin ns++; if (first_s == 0) first_s = k; end
      if (d_ls || d_fs || s_ls || s_fs) nstrobe++;
    end
    n_checks++;
    if (first_d != 4) begin n_fail++; $display("FAIL first_tick_default got=%0d exp=4", first_d); end
    n_checks++;
    if (first_s != 2) begin n_fail++; $display("FAIL first_tick_small got=%0d exp=2", first_s); end
    n_checks++;
    if (nd != 3 || ns != 6) begin n_fail++; $display("FAIL tick_count got=%0d/%0d exp=3/6", nd, ns); end
    n_checks++;
    if (nstrobe != 0) begin n_fail++; $display("FAIL strobe_after_reset got=%0d exp=0", nstrobe); end
  endtask

  task automatic test_default_line();
    int last_ls, hs_low, nls;
    last_ls = -1; hs_low = 0; nls = 0;
    for (int i = 0; i < 10000; i++) begin
      @(negedge clk);
      n_checks++;
      if (d_obs !== d_exp) begin
        n_fail++; $display("FAIL default_line t=%0t got=%h exp=%h", $time, d_obs, d_exp);
      end
`ifdef VGA_FRAME_CNT_EN
      n_checks++;
      if (d_fc !== 8'(md.fc)) begin n_fail++; $display("FAIL default_fc got=%0d exp=%0d", d_fc, md.fc); end
`endif
      if (d_hs == 1'b0) hs_low++;
      if (d_ls) begin
        if (last_ls >= 0) begin
          n_checks += 2;
          if (i - last_ls != 3200) begin
            n_fail++; $display("FAIL line_period got=%0d exp=3200", i - last_ls);
          end
          if (hs_low != 384) begin
            n_fail++; $display("FAIL hsync_low_clks got=%0d exp=384", hs_low);
          end
        end
        last_ls = i; hs_low = 0; nls++;
      end
    end
    n_checks++;
    if (nls < 3) begin n_fail++; $display("FAIL line_count got=%0d exp>=3", nls); end
  endtask

  task automatic test_small_frames();
    int last_fs, nfs;
    bit saw_wrap;
    int prev_fc;
    last_fs = -1; nfs = 0; saw_wrap = 1'b0; prev_fc = -1;
    for (int i = 0; i < 26000; i++) begin
      @(negedge clk);
      n_checks++;
      if (s_obs !== s_exp) begin
        n_fail++; $display("FAIL small_frames t=%0t got=%h exp=%h", $time, s_obs, s_exp);
      end
`ifdef VGA_FRAME_CNT_EN
      n_checks++;
      if (s_fc !== 8'(ms.fc)) begin n_fail++; $display("FAIL small_fc got=%0d exp=%0d", s_fc, ms.fc); end
      if (prev_fc == 255 && s_fc == 8'd0) saw_wrap = 1'b1;
      prev_fc = int'(s_fc);
`endif
      if (s_fs) begin
        if (last_fs >= 0) begin
          n_checks++;
          if (i - last_fs != 96) begin n_fail++; $display("FAIL frame_period got=%0d exp=96", i - last_fs); end
        end
        last_fs = i; nfs++;
      end
    end
    n_checks++;
    if (nfs < 260) begin n_fail++; $display("FAIL frame_count got=%0d exp>=260", nfs); end
`ifdef VGA_FRAME_CNT_EN
    n_checks++;
    if (!saw_wrap) begin n_fail++; $display("FAIL frame_cnt_wrap got=0 exp=1"); end
`endif
  endtask

  task automatic test_enable_hold();
    int waited;
    logic [9:0] x0, y0;
    logic [3:0] sx0, sy0;
    waited = 0;
    while (d_x !== 10'd100 && waited < 4000) begin @(negedge clk); waited++; end
    n_checks++;
    if (d_x !== 10'd100) begin n_fail++; $display("FAIL wait_x100 got=%0d exp=100", d_x); end
    x0 = d_x; y0 = d_y; sx0 = s_x; sy0 = s_y;
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_checks += 2;
      if ({d_x, d_y, d_tick} !== {x0, y0, 1'b0}) begin
        n_fail++; $display("FAIL hold_default got=%h exp=%h", {d_x, d_y, d_tick}, {x0, y0, 1'b0});
      end
      if ({s_x, s_y, s_tick} !== {sx0, sy0, 1'b0}) begin
        n_fail++; $display("FAIL hold_small got=%h exp=%h", {s_x, s_y, s_tick}, {sx0, sy0, 1'b0});
      end
    end
    en = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      n_checks++;
      if (d_obs !== d_exp) begin n_fail++; $display("FAIL resume_phase got=%h exp=%h", d_obs, d_exp); end
    end
  endtask

  task automatic test_random_enable();
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      n_checks += 2;
      if (d_obs !== d_exp) begin n_fail++; $display("FAIL rand_en_default got=%h exp=%h", d_obs, d_exp); end
      if (s_obs !== s_exp) begin n_fail++; $display("FAIL rand_en_small got=%h exp=%h", s_obs, s_exp); end
      en = ($urandom_range(0, 3) != 0);
    end
    en = 1'b1;
  endtask

  task automatic test_reset_mid();
    int waited, nfs;
    waited = 0; nfs = 0;
    while (d_x !== 10'd300 && waited < 4000) begin @(negedge clk); waited++; end
    n_checks++;
    if (d_x !== 10'd300) begin n_fail++; $display("FAIL wait_x300 got=%0d exp=300", d_x); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks += 2;
    if ({d_x, d_y, d_on, d_hs, d_vs, d_fs} !== {20'd0, 1'b0, 1'b1, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL mid_reset_default got=%h exp=%h", {d_x, d_y, d_on, d_hs, d_vs, d_fs}, {20'd0, 4'b0110});
    end
    if ({s_x, s_y, s_on, s_hs, s_vs, s_fs} !== {8'd0, 1'b0, 1'b0, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL mid_reset_small got=%h exp=%h", {s_x, s_y, s_on, s_hs, s_vs, s_fs}, {8'd0, 4'b0010});
    end
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (d_fs || s_fs) nfs++;
      n_checks++;
      if (s_obs !== s_exp) begin n_fail++; $display("FAIL post_reset_small got=%h exp=%h", s_obs, s_exp); end
    end
    n_checks++;
    if (nfs != 0) begin n_fail++; $display("FAIL frame_start_after_reset got=%0d exp=0", nfs); end
  endtask

  initial begin
    rst = 1'b1;
    en  = 1'b0;
    test_reset();
    test_first_tick();
    test_default_line();
    test_small_frames();
    test_enable_hold();
    test_random_enable();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
